// File: rtl/inter_port_demux_if.sv
// Bus bundle for inter_port_demux: inbound crossbar stream, per-queue egress
// streams and the packet statistics.
interface inter_port_demux_if #(
    parameter int NUM_OUT = 4,
    parameter int DST_W   = 4,
    parameter int MSG_W   = 34
);
    logic [MSG_W-1:0]         iInterMsg;
    logic [DST_W-1:0]         iInterDst;
    logic                     iInterVld;
    logic                     oInterRdy;
    logic [NUM_OUT*MSG_W-1:0] oPortMsg;
    logic [NUM_OUT-1:0]       oPortVld;
    logic [NUM_OUT-1:0]       iPortRdy;
    logic [NUM_OUT*16-1:0]    oPktCnt;
    logic [15:0]              oDropCnt;

    modport slave (
        input  iInterMsg, iInterDst, iInterVld, iPortRdy,
        output oInterRdy, oPortMsg, oPortVld, oPktCnt, oDropCnt
    );

    modport master (
        output iInterMsg, iInterDst, iInterVld, iPortRdy,
        input  oInterRdy, oPortMsg, oPortVld, oPktCnt, oDropCnt
    );
endinterface

// File: rtl/inter_port_demux.sv
// Steers whole packets from one crossbar return stream to NUM_OUT egress queues,
// each behind a main+skid register pair, with forwarded/dropped packet counters.
module inter_port_demux #(
    parameter int NUM_OUT = 4,
    parameter int DST_W   = 4,
    parameter int MSG_W   = 34
) (
    input  logic              iClk,
    input  logic              iRst,
    inter_port_demux_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FWD = 2'd1, ST_DROP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [DST_W-1:0] dst_q, dst_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic                     sop, eop, dst_ok, route, acc, fwd_eop;
    logic [DST_W-1:0]         tgt;
    logic [NUM_OUT-1:0]       tgt_hot, skid_full, push_hot, main_vld;
    logic [NUM_OUT*MSG_W-1:0] port_msg;
    logic [NUM_OUT*16-1:0]    pkt_cnt;

    // In IDLE the candidate queue comes straight from the inbound word, so an
    // SOP word can be accepted in the same cycle it is presented.
    always_comb begin
        sop    = bus.iInterMsg[0];
        eop    = bus.iInterMsg[1];
        dst_ok = int'(bus.iInterDst) < NUM_OUT;
        tgt    = (state_q == ST_IDLE) ? bus.iInterDst : dst_q;
        route  = (state_q == ST_FWD) || ((state_q == ST_IDLE) && sop && dst_ok);
    end

    assign bus.oInterRdy = !iRst && (!route || !(|(skid_full & tgt_hot)));
    assign acc           = bus.iInterVld && bus.oInterRdy;
    assign push_hot      = (acc && route) ? tgt_hot : '0;
    assign fwd_eop       = acc && route && eop;

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        drop_cnt_d = drop_cnt_q;
        if (acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (sop && dst_ok) begin
                        dst_d   = bus.iInterDst;
                        state_d = eop ? ST_IDLE : ST_FWD;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                        state_d    = eop ? ST_IDLE : ST_DROP;
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (eop) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            dst_q      <= '0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_lane
            logic [MSG_W-1:0] main_msg_q, main_msg_d, skid_msg_q, skid_msg_d;
            logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
            logic             pop;
            logic [15:0]      pkt_cnt_q, pkt_cnt_d;

            assign tgt_hot[gi] = (tgt == DST_W'(gi));

            // The skid only fills when a word arrives while the main register
            // is stalled; it drains into main on the next downstream pop.
            always_comb begin
                pop        = main_vld_q && bus.iPortRdy[gi];
                main_msg_d = main_msg_q;
                main_vld_d = main_vld_q;
                skid_msg_d = skid_msg_q;
                skid_vld_d = skid_vld_q;
                pkt_cnt_d  = pkt_cnt_q;
                if (skid_vld_q) begin
                    if (pop) begin
                        main_msg_d = skid_msg_q;
                        skid_vld_d = 1'b0;
                    end
                end else if (push_hot[gi]) begin
                    if (!main_vld_q || pop) begin
                        main_msg_d = bus.iInterMsg;
                        main_vld_d = 1'b1;
                    end else begin
                        skid_msg_d = bus.iInterMsg;
                        skid_vld_d = 1'b1;
                    end
                end else if (pop) begin
                    main_vld_d = 1'b0;
                end
                if (fwd_eop && tgt_hot[gi]) pkt_cnt_d = pkt_cnt_q + 16'd1;
            end

            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst) begin
                    main_msg_q <= '0;
                    main_vld_q <= 1'b0;
                    skid_msg_q <= '0;
                    skid_vld_q <= 1'b0;
                    pkt_cnt_q  <= 16'd0;
                end else begin
                    main_msg_q <= main_msg_d;
                    main_vld_q <= main_vld_d;
                    skid_msg_q <= skid_msg_d;
                    skid_vld_q <= skid_vld_d;
                    pkt_cnt_q  <= pkt_cnt_d;
                end
            end

            assign main_vld[gi]                  = main_vld_q;
            assign skid_full[gi]                 = skid_vld_q;
            assign port_msg[gi*MSG_W +: MSG_W]   = main_msg_q;
            assign pkt_cnt[gi*16 +: 16]          = pkt_cnt_q;
        end
    endgenerate

    assign bus.oPortVld = main_vld;
    assign bus.oPortMsg = port_msg;
    assign bus.oPktCnt  = pkt_cnt;
    assign bus.oDropCnt = drop_cnt_q;
endmodule

// File: tb/tb_inter_port_demux.sv
// Directed bench for inter_port_demux: a queue-based packet model checked every
// cycle, plus literal expectations on counters and delivered data.
module tb_inter_port_demux;
    localparam int NUM_OUT = 4;
    localparam int DST_W   = 4;
    localparam int MSG_W   = 34;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inter_port_demux_if #(.NUM_OUT(NUM_OUT), .DST_W(DST_W), .MSG_W(MSG_W)) bus ();

    inter_port_demux #(.NUM_OUT(NUM_OUT), .DST_W(DST_W), .MSG_W(MSG_W)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: words expected on each queue, packet state, counters.
    logic [MSG_W-1:0] exp_q [NUM_OUT][$];
    logic [31:0]      dlog  [NUM_OUT][$];
    logic [15:0]      m_pkt [NUM_OUT];
    logic [15:0]      m_drop;
    int               m_state;   // 0 awaiting SOP, 1 in packet, 2 discarding
    int               m_dst;
    logic [MSG_W-1:0] m_msg;
    int               m_in_dst, m_tgt;
    bit               m_sop, m_eop, m_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MSG_W-1:0] mk(input logic [31:0] d, input logic e, input logic s);
        return {d, e, s};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                exp_q[k].delete();
                m_pkt[k] = 16'd0;
            end
            m_state = 0;
            m_dst   = 0;
            m_drop  = 16'd0;
            chk("rst_vld", bus.oPortVld, 0);
            chk("rst_msg", bus.oPortMsg, 0);
            chk("rst_rdy", bus.oInterRdy, 0);
            chk("rst_drop", bus.oDropCnt, 0);
        end else begin
            m_msg    = bus.iInterMsg;
            m_sop    = m_msg[0];
            m_eop    = m_msg[1];
            m_in_dst = int'(bus.iInterDst);
            if (m_state == 2) m_rdy = 1'b1;
            else if (m_state == 0 && !(m_sop && m_in_dst < NUM_OUT)) m_rdy = 1'b1;
            else begin
                m_tgt = (m_state == 0) ? m_in_dst : m_dst;
                m_rdy = exp_q[m_tgt].size() < 2;
            end
            chk("in_rdy", bus.oInterRdy, m_rdy);
            for (int k = 0; k < NUM_OUT; k++) begin
                chk($sformatf("vld%0d", k), bus.oPortVld[k], exp_q[k].size() != 0);
                chk($sformatf("pktcnt%0d", k), bus.oPktCnt[k*16 +: 16], m_pkt[k]);
            end
            chk("dropcnt", bus.oDropCnt, m_drop);

            for (int k = 0; k < NUM_OUT; k++) begin
                if (bus.oPortVld[k] && bus.iPortRdy[k] && exp_q[k].size() != 0) begin
                    chk($sformatf("msg%0d", k), bus.oPortMsg[k*MSG_W +: MSG_W], exp_q[k][0]);
                    dlog[k].push_back(bus.oPortMsg[k*MSG_W+2 +: 32]);
                    void'(exp_q[k].pop_front());
                end
            end

            if (bus.iInterVld && bus.oInterRdy) begin
                case (m_state)
                    0: begin
                        if (m_sop && m_in_dst < NUM_OUT) begin
                            m_dst = m_in_dst;
                            exp_q[m_dst].push_back(m_msg);
                            if (m_eop) m_pkt[m_dst] = m_pkt[m_dst] + 16'd1;
                            else m_state = 1;
                        end else begin
                            m_drop  = m_drop + 16'd1;
                            m_state = m_eop ? 0 : 2;
                        end
                    end
                    1: begin
                        exp_q[m_dst].push_back(m_msg);
                        if (m_eop) begin
                            m_pkt[m_dst] = m_pkt[m_dst] + 16'd1;
                            m_state = 0;
                        end
                    end
                    default: if (m_eop) m_state = 0;
                endcase
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send(input logic [MSG_W-1:0] m, input logic [DST_W-1:0] d);
        bit done = 1'b0;
        bus.iInterMsg = m;
        bus.iInterDst = d;
        bus.iInterVld = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.oInterRdy;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", done, 1);
    endtask

    task automatic idle(input int n);
        bus.iInterVld = 1'b0;
        bus.iInterMsg = '0;
        bus.iInterDst = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_log(input string nm, input int k, input int base, input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) chk(nm, dlog[k][base+i], first + 32'(i));
    endtask

    initial begin
        int base;
        bus.iInterMsg = '0;
        bus.iInterDst = '0;
        bus.iInterVld = 1'b0;
        bus.iPortRdy  = '1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pktcnt", bus.oPktCnt, 0);
        rst = 1'b0;
        idle(1);

        // 4-word packet to queue 2
        send(mk(32'hA0, 1'b0, 1'b1), 4'd2);
        send(mk(32'hA1, 1'b0, 1'b0), 4'd0);
        send(mk(32'hA2, 1'b0, 1'b0), 4'd0);
        send(mk(32'hA3, 1'b1, 1'b0), 4'd0);
        idle(3);
        chk("t1_pkt2", bus.oPktCnt[2*16 +: 16], 16'd1);
        chk("t1_q2_len", dlog[2].size(), 4);
        chk_log("t1_q2_data", 2, 0, 32'hA0, 4);
        chk("t1_q1_len", dlog[1].size(), 0);

        // single-word packet then back-to-back 3-word packet
        send(mk(32'hB0, 1'b1, 1'b1), 4'd0);
        send(mk(32'hC0, 1'b0, 1'b1), 4'd3);
        send(mk(32'hC1, 1'b0, 1'b0), 4'd3);
        send(mk(32'hC2, 1'b1, 1'b0), 4'd3);
        idle(3);
        chk("t2_pkt0", bus.oPktCnt[0 +: 16], 16'd1);
        chk("t2_pkt3", bus.oPktCnt[3*16 +: 16], 16'd1);
        chk("t2_q0_len", dlog[0].size(), 1);
        chk("t2_q3_len", dlog[3].size(), 3);
        chk_log("t2_q3_data", 3, 0, 32'hC0, 3);

        // 8-word stream to queue 1 with downstream stalls
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(mk(32'hD0 + 32'(i), i == 7, i == 0), 4'd1);
                idle(4);
            end
            begin
                bus.iPortRdy[1] = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1; bus.iPortRdy[1] = 1'b0;
                @(posedge clk); #1; bus.iPortRdy[1] = 1'b0;
                @(posedge clk); #1; bus.iPortRdy[1] = 1'b1;
            end
        join
        chk("t3_q1_len", dlog[1].size(), 8);
        chk_log("t3_q1_data", 1, 0, 32'hD0, 8);
        chk("t3_pkt1", bus.oPktCnt[1*16 +: 16], 16'd1);

        // invalid destination then an orphan burst, all egress stalled
        bus.iPortRdy = '0;
        for (int i = 0; i < 5; i++) send(mk(32'hE0 + 32'(i), i == 4, i == 0), 4'd7);
        send(mk(32'hF0, 1'b0, 1'b0), 4'd0);
        send(mk(32'hF1, 1'b1, 1'b0), 4'd0);
        idle(2);
        chk("t4_drop", bus.oDropCnt, 16'd2);
        chk("t4_novld", bus.oPortVld, 0);
        bus.iPortRdy = '1;

        // reset in the middle of a packet
        send(mk(32'h60, 1'b0, 1'b1), 4'd1);
        send(mk(32'h61, 1'b0, 1'b0), 4'd1);
        bus.iInterMsg = mk(32'h62, 1'b0, 1'b0);
        bus.iInterVld = 1'b1;
        rst = 1'b1;
        #1;
        chk("t5_rst_vld", bus.oPortVld, 0);
        chk("t5_rst_msg", bus.oPortMsg, 0);
        chk("t5_rst_rdy", bus.oInterRdy, 0);
        @(posedge clk); #1;
        bus.iInterVld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        send(mk(32'h63, 1'b0, 1'b0), 4'd1);
        send(mk(32'h64, 1'b0, 1'b0), 4'd1);
        send(mk(32'h65, 1'b1, 1'b0), 4'd1);
        send(mk(32'h80, 1'b0, 1'b1), 4'd1);
        send(mk(32'h81, 1'b1, 1'b0), 4'd2);
        idle(3);
        chk("t5_drop", bus.oDropCnt, 16'd1);
        chk("t5_pkt1", bus.oPktCnt[1*16 +: 16], 16'd1);
        base = dlog[1].size() - 2;
        chk_log("t5_q1_data", 1, base, 32'h80, 2);

        // counter wrap on queue 0
        for (int i = 0; i < 65535; i++) send(mk(32'(i), 1'b1, 1'b1), 4'd0);
        idle(2);
        chk("t6_pkt0_max", bus.oPktCnt[0 +: 16], 16'hFFFF);
        send(mk(32'h12345, 1'b1, 1'b1), 4'd0);
        idle(2);
        chk("t6_pkt0_wrap", bus.oPktCnt[0 +: 16], 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
